// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between up to four requesters and the shared register arbiter.
interface shared_reg_arbiter_if #(
    parameter int W = 8
);
    logic [3:0]     req;
    logic [4*W-1:0] wr_data;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;
    logic [7:0]     xfer_cnt;

    modport master (
        output req, wr_data,
        input  gnt, ack, q, owner, busy, xfer_cnt
    );

    modport slave (
        input  req, wr_data,
        output gnt, ack, q, owner, busy, xfer_cnt
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding a single shared W-bit register.
// Four requesters hold req until acked; one write completes every three cycles.
//
// state | meaning
// IDLE  | waiting for any request; picks winner from rotating pointer
// GRANT | winner holds gnt; write happens if its req is still up
// DONE  | ack pulse cycle; requests ignored
module shared_reg_arbiter #(
    parameter int W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    shared_reg_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_q;
    logic [1:0]   ptr_q;
    logic [1:0]   win_q;
    logic [3:0]   gnt_q;
    logic [3:0]   ack_q;
    logic [W-1:0] q_q;
    logic [1:0]   owner_q;
    logic [7:0]   xfer_cnt_q;

    logic [1:0]   win_d;
    logic         win_vld_d;
    logic [1:0]   cand;

    // Round-robin search from ptr_q; descending loop so the smallest offset wins.
    always_comb begin
        win_d     = ptr_q;
        win_vld_d = 1'b0;
        cand      = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (bus.req[cand]) begin
                win_d     = cand;
                win_vld_d = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered grant/ack and the shared register itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            win_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            ack_q      <= 4'b0000;
            q_q        <= '0;
            owner_q    <= 2'd0;
            xfer_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 4'b0000;
                    if (win_vld_d) begin
                        win_q   <= win_d;
                        gnt_q   <= 4'b0001 << win_d;
                        state_q <= GRANT;
                    end else begin
                        gnt_q <= 4'b0000;
                    end
                end
                GRANT: begin
                    gnt_q <= 4'b0000;
                    if (bus.req[win_q]) begin
                        // Data is taken now, not when the request was raised.
                        q_q        <= bus.wr_data[win_q*W +: W];
                        owner_q    <= win_q;
                        ack_q      <= 4'b0001 << win_q;
                        ptr_q      <= win_q + 2'd1;
                        xfer_cnt_q <= xfer_cnt_q + 8'd1;
                        state_q    <= DONE;
                    end else begin
                        ack_q   <= 4'b0000;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    ack_q   <= 4'b0000;
                    gnt_q   <= 4'b0000;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 4'b0000;
                    gnt_q   <= 4'b0000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.q        = q_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.xfer_cnt = xfer_cnt_q;
endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter W, default 8, data width of the shared register and of each requester data lane.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester write request, bit i = requester i; level, held until ack[i].
REQ-005 wr_data  input  4*W  packed write data; lane i = wr_data[i*W +: W].
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-007 ack  output  4  registered one-cycle write-complete pulse, one-hot.
REQ-008 q  output  W  shared register contents.
REQ-009 owner  output  2  index of requester that last wrote q.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 xfer_cnt  output  8  count of completed writes, wraps 255 -> 0.

Function
REQ-012 States SHALL be IDLE, GRANT, DONE; encoding is free.
REQ-013 IDLE: if req != 0, select winner by round-robin starting at pointer ptr (2 bits), searching ptr, ptr+1, ptr+2, ptr+3 mod 4; gnt <= onehot(winner); state <= GRANT.
REQ-014 IDLE with req == 0: all outputs hold; gnt stays 0.
REQ-015 GRANT with req[winner] still high: q <= lane winner of wr_data, owner <= winner, ack <= onehot(winner), gnt <= 0, ptr <= winner+1 mod 4, xfer_cnt <= xfer_cnt+1, state <= DONE.
REQ-016 GRANT with req[winner] low (abort): gnt <= 0, no write, no ack, ptr/owner/xfer_cnt unchanged, state <= IDLE.
REQ-017 DONE: ack <= 0, state <= IDLE; req ignored in this cycle.
REQ-018 Latency: req sampled at edge k -> gnt high after edge k, q/ack updated after edge k+1, ack low after edge k+2; throughput one write per 3 cycles.
REQ-019 Winner SHALL be latched at IDLE->GRANT; later req changes of other requesters do not alter it.
REQ-020 Data SHALL be sampled at the GRANT->DONE edge, not at request time.
REQ-021 gnt and ack SHALL never have more than one bit set, and never both nonzero in the same cycle.
REQ-022 busy SHALL equal (state != IDLE), derived from registered state.
REQ-023 Requester deasserting req in IDLE before grant SHALL not be granted.
REQ-024 Pointer rotation SHALL guarantee any continuously requesting requester is served within 4 transfers.

Reset
REQ-025 rst high at a rising edge SHALL force q=0, owner=0, gnt=0, ack=0, busy=0, xfer_cnt=0, ptr=0, state=IDLE, overriding all other conditions.
REQ-026 Reset asserted in GRANT SHALL suppress the write and ack; reset in DONE clears the pending ack.
REQ-027 Outputs SHALL be defined (no X/Z) from the first reset edge onward.

Verification
REQ-028 Reset, then req=4'b0100, lane2=8'hA5 -> gnt=4'b0100 next cycle; following cycle q=8'hA5, ack=4'b0100, owner=2, xfer_cnt=1; then ack=0, busy=0.
REQ-029 Reset, req=4'b1111 held, lanes 8'h10/11/12/13, each released after its ack -> grant order 0,1,2,3, q sequence 10,11,12,13, xfer_cnt=4.
REQ-030 After requester 1 served (ptr=2), req=4'b0011 -> requester 0 granted next, not 1.
REQ-031 req=4'b0001, drop req[0] during GRANT -> no ack, q unchanged, xfer_cnt unchanged, next winner search starts at ptr unchanged.
REQ-032 rst asserted in the GRANT cycle with req=4'b1000, lane3=8'hFF -> q=0, ack=0, gnt=0, state IDLE after that edge.
REQ-033 256 completed writes from reset -> xfer_cnt wraps to 0; check gnt/ack one-hot and mutually exclusive every cycle.
